// File: rtl/dispatch_scheduler_pkg.sv
// Shared types and default sizing for the rename-to-RS dispatch scheduler.
// Combinational/registered stages exchange per-slot routing decisions via DispRouteSt.
package dispatch_scheduler_pkg;

    localparam int DECODE_WIDTH     = 2;
    localparam int RS_NUM_DEFAULT   = 4;
    localparam int RS_DEPTH_DEFAULT = 8;
    localparam int RS_CREDIT_W      = $clog2(RS_DEPTH_DEFAULT + 1);
    localparam int RS_SEL_W         = $clog2(RS_NUM_DEFAULT);
    localparam int RS_PORT_W        = 2;

    typedef struct packed {
        logic [3:0] opcode;
        logic [6:0] pdst;
        logic [5:0] rob_idx;
    } RsBaseSt;

    typedef struct packed {
        logic                 valid;
        logic [RS_SEL_W-1:0]  rs;
        logic [RS_PORT_W-1:0] port;
    } DispRouteSt;

endpackage

// File: rtl/dispatch_scheduler_if.sv
// Dispatch group in, per-RS write ports and credit state out.
// No ready back-pressure from the RS side; acceptance is the only throttle.
interface dispatch_scheduler_if
    import dispatch_scheduler_pkg::*;
#(
    parameter int RS_NUM      = RS_NUM_DEFAULT,
    parameter int RS_DEPTH    = RS_DEPTH_DEFAULT,
    parameter int RS_WR_WIDTH = 2,
    parameter int FREE_WIDTH  = 2,
    parameter int DISP_WIDTH  = DECODE_WIDTH
);
    localparam int SEL_W    = $clog2(RS_NUM);
    localparam int FREE_W   = $clog2(FREE_WIDTH + 1);
    localparam int CREDIT_W = $clog2(RS_DEPTH + 1);

    logic                                  flush_i;
    logic    [DISP_WIDTH-1:0]              disp_valid_i;
    logic    [DISP_WIDTH-1:0][SEL_W-1:0]   disp_rs_sel_i;
    RsBaseSt [DISP_WIDTH-1:0]              disp_base_i;
    logic    [DISP_WIDTH-1:0]              disp_accept_o;
    logic    [RS_NUM-1:0][FREE_W-1:0]      rs_free_cnt_i;
    logic    [RS_NUM-1:0][RS_WR_WIDTH-1:0] rs_wr_valid_o;
    RsBaseSt [RS_NUM-1:0][RS_WR_WIDTH-1:0] rs_base_o;
    logic    [RS_NUM-1:0][CREDIT_W-1:0]    credit_o;

    modport master (
        output flush_i, disp_valid_i, disp_rs_sel_i, disp_base_i, rs_free_cnt_i,
        input  disp_accept_o, rs_wr_valid_o, rs_base_o, credit_o
    );

    modport slave (
        input  flush_i, disp_valid_i, disp_rs_sel_i, disp_base_i, rs_free_cnt_i,
        output disp_accept_o, rs_wr_valid_o, rs_base_o, credit_o
    );

endinterface

// File: rtl/dispatch_scheduler_route.sv
// In-order prefix acceptance and per-RS write-port assignment; purely combinational.
// A slot is refused when its RS lacks credit or write ports, and that refusal ends the walk.
module dispatch_route
    import dispatch_scheduler_pkg::*;
#(
    parameter int RS_NUM      = RS_NUM_DEFAULT,
    parameter int RS_WR_WIDTH = 2,
    parameter int DISP_WIDTH  = DECODE_WIDTH,
    parameter int CREDIT_W    = RS_CREDIT_W,
    localparam int SEL_W      = $clog2(RS_NUM)
) (
    input  logic       [DISP_WIDTH-1:0]            valid,
    input  logic       [DISP_WIDTH-1:0][SEL_W-1:0] rs_sel,
    input  logic       [RS_NUM-1:0][CREDIT_W-1:0]  credit,
    output logic       [DISP_WIDTH-1:0]            accept,
    output DispRouteSt [DISP_WIDTH-1:0]            route,
    output logic       [RS_NUM-1:0][CREDIT_W-1:0]  rs_used
);

    always_comb begin
        logic             walking;
        logic [SEL_W-1:0] r;
        accept  = '0;
        route   = '0;
        rs_used = '0;
        walking = 1'b1;
        r       = '0;
        for (int j = 0; j < DISP_WIDTH; j++) begin
            r = rs_sel[j];
            // rs_used doubles as the next free port index for that RS
            if (walking && valid[j] && (credit[r] > rs_used[r]) &&
                (rs_used[r] < CREDIT_W'(RS_WR_WIDTH))) begin
                accept[j]      = 1'b1;
                route[j].valid = 1'b1;
                route[j].rs    = RS_SEL_W'(r);
                route[j].port  = RS_PORT_W'(rs_used[r]);
                rs_used[r]     = rs_used[r] + CREDIT_W'(1);
            end else begin
                walking = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// Credit-based dispatch from rename into the reservation stations.
// Accepted slots reach the RS write ports one cycle later; credits gate acceptance instead of RS ready.
module dispatch_scheduler
    import dispatch_scheduler_pkg::*;
#(
    parameter int RS_NUM      = RS_NUM_DEFAULT,
    parameter int RS_DEPTH    = RS_DEPTH_DEFAULT,
    parameter int RS_WR_WIDTH = 2,
    parameter int FREE_WIDTH  = 2,
    parameter int DISP_WIDTH  = DECODE_WIDTH
) (
    input logic           clk,
    input logic           a_rst_n,
    dispatch_scheduler_if.slave dif
);
    localparam int CREDIT_W = $clog2(RS_DEPTH + 1);

    logic [1:0] rst_sync;
    logic       rst_n;

    logic       [RS_NUM-1:0][CREDIT_W-1:0]    credit_q;
    logic       [RS_NUM-1:0][CREDIT_W-1:0]    credit_d;
    logic       [RS_NUM-1:0][CREDIT_W-1:0]    rs_used;
    logic       [RS_NUM-1:0]                  over_depth;
    logic       [DISP_WIDTH-1:0]              route_accept;
    DispRouteSt [DISP_WIDTH-1:0]              route;
    logic       [RS_NUM-1:0][RS_WR_WIDTH-1:0] wr_valid_q;
    logic       [RS_NUM-1:0][RS_WR_WIDTH-1:0] wr_valid_d;
    RsBaseSt    [RS_NUM-1:0][RS_WR_WIDTH-1:0] base_q;
    RsBaseSt    [RS_NUM-1:0][RS_WR_WIDTH-1:0] base_d;

    // Assert asynchronously, release synchronously to core timing
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    dispatch_route #(
        .RS_NUM      (RS_NUM),
        .RS_WR_WIDTH (RS_WR_WIDTH),
        .DISP_WIDTH  (DISP_WIDTH),
        .CREDIT_W    (CREDIT_W)
    ) u_route (
        .valid   (dif.disp_valid_i),
        .rs_sel  (dif.disp_rs_sel_i),
        .credit  (credit_q),
        .accept  (route_accept),
        .route   (route),
        .rs_used (rs_used)
    );

    always_comb begin
        logic [CREDIT_W:0] sum;
        sum        = '0;
        credit_d   = credit_q;
        over_depth = '0;
        for (int r = 0; r < RS_NUM; r++) begin
            sum = {1'b0, credit_q[r]} + (CREDIT_W+1)'(dif.rs_free_cnt_i[r]) - {1'b0, rs_used[r]};
            over_depth[r] = !dif.flush_i && (sum > (CREDIT_W+1)'(RS_DEPTH));
            credit_d[r]   = dif.flush_i ? CREDIT_W'(RS_DEPTH) : sum[CREDIT_W-1:0];
        end
    end

    // Idle ports keep their old payload; only the strobe matters there
    always_comb begin
        wr_valid_d = '0;
        base_d     = base_q;
        for (int j = 0; j < DISP_WIDTH; j++) begin
            if (route[j].valid && !dif.flush_i) begin
                wr_valid_d[route[j].rs][route[j].port] = 1'b1;
                base_d[route[j].rs][route[j].port]     = dif.disp_base_i[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q   <= {RS_NUM{CREDIT_W'(RS_DEPTH)}};
            wr_valid_q <= '0;
            base_q     <= '0;
        end else begin
            credit_q   <= credit_d;
            wr_valid_q <= wr_valid_d;
            base_q     <= base_d;
        end
    end

    // A free count pushing credit past depth means the RS returned entries it never held
    assert property (@(posedge clk) disable iff (!rst_n) over_depth == '0);

    assign dif.disp_accept_o = dif.flush_i ? '0 : route_accept;
    assign dif.rs_wr_valid_o = wr_valid_q;
    assign dif.rs_base_o     = base_q;
    assign dif.credit_o      = credit_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: default config plus a single-write-port instance.
module tb_dispatch_scheduler;
    import dispatch_scheduler_pkg::*;

    logic clk;
    logic a_rst_n;
    int   errors = 0;
    int   checks = 0;

    dispatch_scheduler_if dif ();
    dispatch_scheduler_if #(.RS_WR_WIDTH(1)) dif1 ();

    dispatch_scheduler u_dut (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .dif     (dif.slave)
    );

    dispatch_scheduler #(.RS_WR_WIDTH(1)) u_dut_w1 (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .dif     (dif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic RsBaseSt mkb(input logic [5:0] t);
        RsBaseSt b;
        b.opcode  = t[3:0] ^ 4'h5;
        b.pdst    = {1'b1, t};
        b.rob_idx = t;
        return b;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [1:0] s0, input logic [1:0] s1,
                         input logic [5:0] t0, input logic [5:0] t1);
        dif.disp_valid_i     = v;
        dif.disp_rs_sel_i[0] = s0;
        dif.disp_rs_sel_i[1] = s1;
        dif.disp_base_i[0]   = mkb(t0);
        dif.disp_base_i[1]   = mkb(t1);
        #1;
    endtask

    initial begin
        a_rst_n            = 1'b1;
        dif.flush_i        = 1'b0;
        dif.disp_valid_i   = '0;
        dif.disp_rs_sel_i  = '0;
        dif.disp_base_i    = '0;
        dif.rs_free_cnt_i  = '0;
        dif1.flush_i       = 1'b0;
        dif1.disp_valid_i  = '0;
        dif1.disp_rs_sel_i = '0;
        dif1.disp_base_i   = '0;
        dif1.rs_free_cnt_i = '0;
        #2 a_rst_n = 1'b0;
        tick();
        tick();
        check("reset_credit", 32'(dif.credit_o), 32'h8888);
        check("reset_wr_valid", 32'(dif.rs_wr_valid_o), 32'h0);
        check("reset_base", 32'(dif.rs_base_o[2][0]), 32'h0);
        a_rst_n = 1'b1;
        tick(); tick(); tick();

        // single dispatch to RS2
        drive(2'b01, 2'd2, 2'd0, 6'd1, 6'd0);
        check("single_accept", 32'(dif.disp_accept_o), 32'h1);
        tick();
        drive(2'b00, 2'd0, 2'd0, 6'd0, 6'd0);
        check("single_wr_valid", 32'(dif.rs_wr_valid_o), 32'h10);
        check("single_credit", 32'(dif.credit_o), 32'h8788);
        check("single_base", 32'(dif.rs_base_o[2][0]), 32'(mkb(6'd1)));

        // fill RS0: four cycles of two writes
        drive(2'b11, 2'd0, 2'd0, 6'd10, 6'd11);
        check("fill_accept", 32'(dif.disp_accept_o), 32'h3);
        tick();
        check("fill_wr_valid", 32'(dif.rs_wr_valid_o), 32'h03);
        check("fill_port0", 32'(dif.rs_base_o[0][0]), 32'(mkb(6'd10)));
        check("fill_port1", 32'(dif.rs_base_o[0][1]), 32'(mkb(6'd11)));
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'd0, 2'd0, 6'd12, 6'd13);
            tick();
        end
        drive(2'b01, 2'd0, 2'd0, 6'd14, 6'd0);
        check("exhaust_accept", 32'(dif.disp_accept_o), 32'h0);
        check("exhaust_credit", 32'(dif.credit_o), 32'h8780);

        // credit return only counts from the next cycle
        dif.rs_free_cnt_i[0] = 2'd2;
        drive(2'b11, 2'd0, 2'd0, 6'd15, 6'd16);
        check("free_same_cycle", 32'(dif.disp_accept_o), 32'h0);
        tick();
        dif.rs_free_cnt_i = '0;
        #1;
        check("free_credit", 32'(dif.credit_o), 32'h8782);
        check("free_next_cycle", 32'(dif.disp_accept_o), 32'h3);
        tick();
        drive(2'b00, 2'd0, 2'd0, 6'd0, 6'd0);
        check("free_drain", 32'(dif.credit_o), 32'h8780);

        // drain RS3 to 0, RS1 to 5
        drive(2'b11, 2'd3, 2'd3, 6'd20, 6'd21);
        repeat (4) tick();
        drive(2'b11, 2'd1, 2'd1, 6'd22, 6'd23);
        tick();
        drive(2'b01, 2'd1, 2'd0, 6'd24, 6'd0);
        tick();
        drive(2'b00, 2'd0, 2'd0, 6'd0, 6'd0);
        check("prefix_setup", 32'(dif.credit_o), 32'h0750);
        drive(2'b11, 2'd3, 2'd1, 6'd25, 6'd26);
        check("prefix_stop", 32'(dif.disp_accept_o), 32'h0);
        drive(2'b11, 2'd1, 2'd2, 6'd27, 6'd28);
        check("mixed_accept", 32'(dif.disp_accept_o), 32'h3);
        tick();
        drive(2'b00, 2'd0, 2'd0, 6'd0, 6'd0);
        check("mixed_wr_valid", 32'(dif.rs_wr_valid_o), 32'h14);
        check("mixed_credit", 32'(dif.credit_o), 32'h0640);
        check("mixed_base_rs2", 32'(dif.rs_base_o[2][0]), 32'(mkb(6'd28)));

        // simultaneous free and accept on RS1
        drive(2'b11, 2'd1, 2'd1, 6'd30, 6'd31);
        tick();
        drive(2'b01, 2'd1, 2'd0, 6'd32, 6'd0);
        tick();
        drive(2'b00, 2'd0, 2'd0, 6'd0, 6'd0);
        check("net_setup", 32'(dif.credit_o), 32'h0610);
        dif.rs_free_cnt_i[1] = 2'd2;
        drive(2'b01, 2'd1, 2'd0, 6'd33, 6'd0);
        check("net_accept", 32'(dif.disp_accept_o), 32'h1);
        tick();
        dif.rs_free_cnt_i = '0;
        drive(2'b00, 2'd0, 2'd0, 6'd0, 6'd0);
        check("net_credit", 32'(dif.credit_o), 32'h0620);

        // flush with RS0 at credit 3
        dif.rs_free_cnt_i[0] = 2'd2;
        tick();
        dif.rs_free_cnt_i[0] = 2'd1;
        tick();
        dif.rs_free_cnt_i = '0;
        #1;
        check("flush_setup", 32'(dif.credit_o), 32'h0623);
        dif.flush_i = 1'b1;
        dif.rs_free_cnt_i[1] = 2'd2;
        drive(2'b11, 2'd2, 2'd2, 6'd40, 6'd41);
        check("flush_accept", 32'(dif.disp_accept_o), 32'h0);
        tick();
        dif.flush_i = 1'b0;
        dif.rs_free_cnt_i = '0;
        drive(2'b00, 2'd0, 2'd0, 6'd0, 6'd0);
        check("flush_credit", 32'(dif.credit_o), 32'h8888);
        check("flush_wr_valid", 32'(dif.rs_wr_valid_o), 32'h0);

        // asynchronous reset clears in-flight writes immediately
        drive(2'b11, 2'd1, 2'd1, 6'd42, 6'd43);
        tick();
        drive(2'b00, 2'd0, 2'd0, 6'd0, 6'd0);
        check("pre_rst_wr_valid", 32'(dif.rs_wr_valid_o), 32'h0C);
        check("pre_rst_credit", 32'(dif.credit_o), 32'h8868);
        #2 a_rst_n = 1'b0;
        #1;
        check("async_rst_wr_valid", 32'(dif.rs_wr_valid_o), 32'h0);
        check("async_rst_credit", 32'(dif.credit_o), 32'h8888);
        check("async_rst_base", 32'(dif.rs_base_o[1][0]), 32'h0);
        tick();
        a_rst_n = 1'b1;
        tick(); tick(); tick();

        // single write port per RS: second slot to the same RS waits a cycle
        dif1.disp_valid_i     = 2'b11;
        dif1.disp_rs_sel_i[0] = 2'd1;
        dif1.disp_rs_sel_i[1] = 2'd1;
        dif1.disp_base_i[0]   = mkb(6'd50);
        dif1.disp_base_i[1]   = mkb(6'd51);
        #1;
        check("w1_conflict_accept", 32'(dif1.disp_accept_o), 32'h1);
        tick();
        dif1.disp_valid_i     = 2'b01;
        dif1.disp_base_i[0]   = mkb(6'd51);
        #1;
        check("w1_retry_accept", 32'(dif1.disp_accept_o), 32'h1);
        check("w1_first_wr_valid", 32'(dif1.rs_wr_valid_o), 32'h2);
        check("w1_first_base", 32'(dif1.rs_base_o[1][0]), 32'(mkb(6'd50)));
        tick();
        dif1.disp_valid_i = 2'b00;
        #1;
        check("w1_second_wr_valid", 32'(dif1.rs_wr_valid_o), 32'h2);
        check("w1_second_base", 32'(dif1.rs_base_o[1][0]), 32'(mkb(6'd51)));
        check("w1_credit", 32'(dif1.credit_o), 32'h8868);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
